// File: rtl/ram_responder_pkg.sv
// Shared types and constants for the RAM1 data-memory responder.
package ram_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Encoding of RAM1_Read_H_Write_L.
  localparam logic MEM_READ  = 1'b1;
  localparam logic MEM_WRITE = 1'b0;

  // Wide enough for WaitStates up to 15.
  localparam int unsigned CntWidth = 4;

endpackage

// File: rtl/word_ram_array.sv
// Synchronous single-port word array; read data is registered on the access edge.
module word_ram_array #(
  parameter int unsigned AddressWidth = 8,
  parameter int unsigned DataWidth    = 32
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic                    re,
  input  logic [AddressWidth-1:0] addr,
  input  logic [DataWidth-1:0]    wdata,
  output logic [DataWidth-1:0]    rdata
);

  logic [DataWidth-1:0] mem [2**AddressWidth];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/ram_responder.sv
// RAM1 responder: latches a request, waits WaitStates cycles, accesses the array,
// then holds RAM1_MFC until the processor drops its request.
module ram_responder
  import ram_responder_pkg::*;
#(
  parameter int unsigned AddressWidth = 8,
  parameter int unsigned WaitStates   = 2,
  parameter int unsigned DataWidth    = 32
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 RAM1_Request,
  input  logic [31:0]          RAM1_Address,
  input  logic                 RAM1_Read_H_Write_L,
  input  logic [DataWidth-1:0] RAM1_Data_In,
  output logic [DataWidth-1:0] RAM1_Data_Out,
  output logic                 RAM1_MFC,
  output logic                 RAM1_Addr_Error
);

  state_e                state_q, state_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic [31:0]           addr_q;
  logic                  rw_q;
  logic [DataWidth-1:0]  data_q;
  logic                  mfc_q, err_q, zero_q;
  logic                  latch, access, oor, we, re;
  logic [31:0]           acc_addr;
  logic                  acc_rw;
  logic [DataWidth-1:0]  acc_data;
  logic [DataWidth-1:0]  rdata;

  // With zero wait states the access happens on the accepting edge, so use live inputs.
  always_comb begin
    acc_addr = (state_q == ST_IDLE) ? RAM1_Address        : addr_q;
    acc_rw   = (state_q == ST_IDLE) ? RAM1_Read_H_Write_L : rw_q;
    acc_data = (state_q == ST_IDLE) ? RAM1_Data_In        : data_q;
    oor      = (acc_addr >> AddressWidth) != 32'd0;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    latch   = 1'b0;
    access  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (RAM1_Request) begin
          latch = 1'b1;
          if (WaitStates == 0) begin
            access  = 1'b1;
            state_d = ST_DONE;
          end else begin
            cnt_d   = CntWidth'(WaitStates - 1);
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) begin
          access  = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        if (!RAM1_Request) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset must veto the array write even though the array itself has no reset.
  assign we = access & (acc_rw == MEM_WRITE) & ~oor & ~Reset;
  assign re = access & (acc_rw == MEM_READ) & ~oor & ~Reset;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rw_q    <= MEM_READ;
      data_q  <= '0;
      mfc_q   <= 1'b0;
      err_q   <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch) begin
        addr_q <= RAM1_Address;
        rw_q   <= RAM1_Read_H_Write_L;
        data_q <= RAM1_Data_In;
      end
      mfc_q <= (state_d == ST_DONE);
      if (access) begin
        err_q <= oor;
        if (acc_rw == MEM_READ) zero_q <= oor;
      end else if (state_d == ST_IDLE) begin
        err_q <= 1'b0;
      end
    end
  end

  word_ram_array #(
    .AddressWidth(AddressWidth),
    .DataWidth   (DataWidth)
  ) u_array (
    .clk  (Clock),
    .we   (we),
    .re   (re),
    .addr (acc_addr[AddressWidth-1:0]),
    .wdata(acc_data),
    .rdata(rdata)
  );

  // zero_q forces 0 after reset or an out-of-range read without touching the array.
  assign RAM1_Data_Out   = zero_q ? '0 : rdata;
  assign RAM1_MFC        = mfc_q;
  assign RAM1_Addr_Error = err_q;

endmodule
